// File: rtl/sb_spi_sequencer.sv
// System-bus sequencer for the iCE40UP SPI hard IP: one-shot register init, then byte transfers.
// Optional `SPI_BURST_CS_EN: tx_last-framed bursts with explicit SPICSR chip-select control.
module sb_spi_sequencer #(
  parameter logic [7:0] CR0_VAL     = 8'hFF,
  parameter logic [7:0] CR1_VAL     = 8'h80,
  parameter logic [7:0] CR2_VAL     = 8'hC0,
  parameter logic [7:0] BR_VAL      = 8'h3F,
  parameter logic [3:0] ACK_TIMEOUT = 4'd15,
  parameter logic [7:0] POLL_LIMIT  = 8'd255
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ip_done,
  output logic       sb_stb,
  output logic       sb_wr,
  output logic [7:0] sb_adr,
  output logic [7:0] sb_dat_o,
  input  logic [7:0] sb_dat_i,
  input  logic       sb_ack,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       init_done,
  output logic       busy,
  output logic       err,
  input  logic       err_clear
);

  // WAIT_IP/INITn: bring-up | IDLE: ready | POLL_T..RD_RX: one byte | CS_*: chip select | ERROR: sticky stop
  typedef enum logic [3:0] {
    S_WAIT_IP, S_INIT0, S_INIT1, S_INIT2, S_INIT3, S_IDLE, S_CS_ON, S_POLL_T,
    S_WR_TX, S_POLL_R, S_RD_RX, S_CS_OFF, S_CS_ERR, S_ERROR
  } state_t;

  state_t     r_state, w_state_nx, w_err_tgt;
  logic       r_stb, r_wr, r_ip_q, r_init_done, r_err, r_rx_valid;
  logic [7:0] r_adr, r_dat, r_poll, r_tx_byte, r_rx_data;
  logic [3:0] r_tmo;
  logic       w_stb_nx, w_wr_nx, w_init_done_nx, w_err_nx, w_rx_valid_nx;
  logic [7:0] w_adr_nx, w_dat_nx, w_poll_nx, w_tx_byte_nx, w_rx_data_nx;
  logic [3:0] w_tmo_nx;
  logic       w_req, w_req_wr, w_done, w_tmo_abort;
  logic [7:0] w_req_adr, w_req_dat;
`ifdef SPI_BURST_CS_EN
  logic       r_tx_last, r_burst_open, w_tx_last_nx, w_burst_open_nx;
`else
  logic       w_unused_tx_last;
  assign w_unused_tx_last = tx_last;
`endif

  assign w_done      = r_stb & sb_ack;
  assign w_tmo_abort = r_stb & ~sb_ack & (r_tmo <= 4'd1);

  always_comb begin
    w_req     = 1'b1;
    w_req_wr  = 1'b1;
    w_req_adr = 8'h00;
    w_req_dat = 8'h00;
    case (r_state)
      S_INIT0:  begin w_req_adr = 8'h08; w_req_dat = CR0_VAL; end
      S_INIT1:  begin w_req_adr = 8'h09; w_req_dat = CR1_VAL; end
      S_INIT2:  begin w_req_adr = 8'h0A; w_req_dat = CR2_VAL; end
      S_INIT3:  begin w_req_adr = 8'h0B; w_req_dat = BR_VAL; end
      S_CS_ON:  begin w_req_adr = 8'h0F; w_req_dat = 8'hFE; end
      S_CS_OFF, S_CS_ERR: begin w_req_adr = 8'h0F; w_req_dat = 8'hFF; end
      S_POLL_T, S_POLL_R: begin w_req_wr = 1'b0; w_req_adr = 8'h0C; end
      S_WR_TX:  begin w_req_adr = 8'h0D; w_req_dat = r_tx_byte; end
      S_RD_RX:  begin w_req_wr = 1'b0; w_req_adr = 8'h0E; end
      default:  w_req = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nx     = r_state;
    w_stb_nx       = r_stb;
    w_wr_nx        = r_wr;
    w_adr_nx       = r_adr;
    w_dat_nx       = r_dat;
    w_tmo_nx       = r_tmo;
    w_poll_nx      = r_poll;
    w_tx_byte_nx   = r_tx_byte;
    w_init_done_nx = r_init_done;
    w_err_nx       = err_clear ? 1'b0 : r_err;
    w_rx_valid_nx  = 1'b0;
    w_rx_data_nx   = r_rx_data;
`ifdef SPI_BURST_CS_EN
    w_tx_last_nx    = r_tx_last;
    w_burst_open_nx = r_burst_open;
    w_err_tgt       = S_CS_ERR;
`else
    w_err_tgt       = S_ERROR;
`endif

    // Bus-cycle engine: a bus state entered with strobe low always spends one idle clock first.
    if (w_req) begin
      if (!r_stb) begin
        w_stb_nx = 1'b1;
        w_wr_nx  = w_req_wr;
        w_adr_nx = w_req_adr;
        w_dat_nx = w_req_dat;
        w_tmo_nx = ACK_TIMEOUT;
      end else if (sb_ack || w_tmo_abort) begin
        w_stb_nx = 1'b0;
      end else begin
        w_tmo_nx = r_tmo - 4'd1;
      end
    end

    case (r_state)
      S_WAIT_IP: if (ip_done && r_ip_q) w_state_nx = S_INIT0;
      S_INIT0:   if (w_done) w_state_nx = S_INIT1;
      S_INIT1:   if (w_done) w_state_nx = S_INIT2;
      S_INIT2:   if (w_done) w_state_nx = S_INIT3;
      S_INIT3:   if (w_done) begin w_state_nx = S_IDLE; w_init_done_nx = 1'b1; end
      S_IDLE: if (tx_valid) begin
        w_tx_byte_nx = tx_data;
        w_state_nx   = S_POLL_T;
`ifdef SPI_BURST_CS_EN
        w_tx_last_nx = tx_last;
        if (!r_burst_open) w_state_nx = S_CS_ON;
`endif
      end
      S_CS_ON: if (w_done) begin
        w_state_nx = S_POLL_T;
`ifdef SPI_BURST_CS_EN
        w_burst_open_nx = 1'b1;
`endif
      end
      S_POLL_T, S_POLL_R: if (w_done) begin
        if ((r_state == S_POLL_T) ? sb_dat_i[4] : sb_dat_i[3]) begin
          w_state_nx = (r_state == S_POLL_T) ? S_WR_TX : S_RD_RX;
        end else if (r_poll == POLL_LIMIT - 8'd1) begin
          w_err_nx   = 1'b1;
          w_state_nx = w_err_tgt;
        end else begin
          w_poll_nx = r_poll + 8'd1;
        end
      end
      S_WR_TX: if (w_done) w_state_nx = S_POLL_R;
      S_RD_RX: if (w_done) begin
        w_rx_valid_nx = 1'b1;
        w_rx_data_nx  = sb_dat_i;
        w_state_nx    = S_IDLE;
`ifdef SPI_BURST_CS_EN
        if (r_tx_last) w_state_nx = S_CS_OFF;
`endif
      end
      S_CS_OFF: if (w_done) begin
        w_state_nx = S_IDLE;
`ifdef SPI_BURST_CS_EN
        w_burst_open_nx = 1'b0;
`endif
      end
      S_CS_ERR: if (w_done) w_state_nx = S_ERROR;
      S_ERROR: if (err_clear) w_state_nx = r_init_done ? S_IDLE : S_WAIT_IP;
      default: w_state_nx = S_WAIT_IP;
    endcase

    if (w_tmo_abort) begin
      if (r_state != S_CS_ERR) w_err_nx = 1'b1;
      w_state_nx = (r_state == S_CS_ERR) ? S_ERROR : w_err_tgt;
    end

    // Losing IPDONE invalidates the IP configuration; ERROR stays put until cleared.
    if (!ip_done) begin
      w_init_done_nx = 1'b0;
      if (r_state != S_WAIT_IP && r_state != S_ERROR) begin
        w_state_nx = S_WAIT_IP;
        w_stb_nx   = 1'b0;
`ifdef SPI_BURST_CS_EN
        w_burst_open_nx = 1'b0;
`endif
      end
    end

    if (w_state_nx != r_state) w_poll_nx = 8'd0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_WAIT_IP;
      r_stb       <= 1'b0;
      r_wr        <= 1'b0;
      r_adr       <= 8'h00;
      r_dat       <= 8'h00;
      r_tmo       <= 4'd0;
      r_poll      <= 8'd0;
      r_ip_q      <= 1'b0;
      r_tx_byte   <= 8'h00;
      r_init_done <= 1'b0;
      r_err       <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_rx_data   <= 8'h00;
`ifdef SPI_BURST_CS_EN
      r_tx_last    <= 1'b0;
      r_burst_open <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nx;
      r_stb       <= w_stb_nx;
      r_wr        <= w_wr_nx;
      r_adr       <= w_adr_nx;
      r_dat       <= w_dat_nx;
      r_tmo       <= w_tmo_nx;
      r_poll      <= w_poll_nx;
      r_ip_q      <= ip_done;
      r_tx_byte   <= w_tx_byte_nx;
      r_init_done <= w_init_done_nx;
      r_err       <= w_err_nx;
      r_rx_valid  <= w_rx_valid_nx;
      r_rx_data   <= w_rx_data_nx;
`ifdef SPI_BURST_CS_EN
      r_tx_last    <= w_tx_last_nx;
      r_burst_open <= w_burst_open_nx;
`endif
    end
  end

  assign sb_stb    = r_stb;
  assign sb_wr     = r_wr;
  assign sb_adr    = r_adr;
  assign sb_dat_o  = r_dat;
  assign tx_ready  = (r_state == S_IDLE);
  assign busy      = r_state inside {S_CS_ON, S_POLL_T, S_WR_TX, S_POLL_R, S_RD_RX, S_CS_OFF};
  assign rx_valid  = r_rx_valid;
  assign rx_data   = r_rx_data;
  assign init_done = r_init_done;
  assign err       = r_err;

endmodule
